// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// mc_pkg : shared encodings for the multicycle controller
// Revision: 1.0
// ============================================================================
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC     = 4'd2,
    S_ALU_WB   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ERROR    = 4'd10
  } state_e;

  typedef enum logic [3:0] {
    CL_NONE = 4'd0,
    CL_ADDU = 4'd1,
    CL_SUBU = 4'd2,
    CL_ORI  = 4'd3,
    CL_LUI  = 4'd4,
    CL_LW   = 4'd5,
    CL_SW   = 4'd6,
    CL_BEQ  = 4'd7,
    CL_JAL  = 4'd8,
    CL_JR   = 4'd9,
    CL_NOP  = 4'd10
  } iclass_e;

  localparam logic [2:0] ALU_NONE = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_LUI  = 3'd4;

  localparam logic [1:0] NPC_PC4    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_J26    = 2'd2;
  localparam logic [1:0] NPC_REG    = 2'd3;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  localparam logic [1:0] RD_RD  = 2'd0;
  localparam logic [1:0] RD_RT  = 2'd1;
  localparam logic [1:0] RD_R31 = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_NOP  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  function automatic logic is_i_type(input iclass_e c);
    return (c == CL_ORI) || (c == CL_LUI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
// mc_decode : combinational opcode/funct -> instruction class classifier
// Revision: 1.0
// ============================================================================
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_e    cls,
  output logic       illegal
);

  always_comb begin
    cls     = CL_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_NOP:  cls = CL_NOP;
          FN_ADDU: cls = CL_ADDU;
          FN_SUBU: cls = CL_SUBU;
          FN_JR:   cls = CL_JR;
          default: illegal = 1'b1;
        endcase
      end
      OP_ORI:  cls = CL_ORI;
      OP_LUI:  cls = CL_LUI;
      OP_LW:   cls = CL_LW;
      OP_SW:   cls = CL_SW;
      OP_BEQ:  cls = CL_BEQ;
      OP_JAL:  cls = CL_JAL;
      default: illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// mc_ctrl : multicycle MIPS-subset control FSM with memory wait watchdog
// Revision: 1.0
// ============================================================================
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       mem_req,
  output logic       mem_we,
  output logic       alu_src_b,
  output logic       ext_sign,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic [1:0] npc_sel,
  output logic [2:0] alu_op,
  output logic       retire,
  output logic       err,
  output logic [3:0] state
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  state_e        state_q, state_d;
  iclass_e       class_q, class_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          retire_q, retire_d;

  iclass_e dec_cls;
  logic    dec_illegal;
  logic    timeout;

  mc_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  assign timeout = (wait_q == CW'(MAX_WAIT));

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    wait_d  = '0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_ERROR;
        else              wait_d  = wait_q + CW'(1);
      end
      S_DECODE: begin
        class_d = dec_cls;
        if (dec_illegal) begin
          state_d = S_ERROR;
        end else begin
          case (dec_cls)
            CL_ADDU, CL_SUBU, CL_ORI, CL_LUI: state_d = S_EXEC;
            CL_LW, CL_SW:                     state_d = S_MEM_ADDR;
            CL_BEQ:                           state_d = S_BRANCH;
            CL_JAL, CL_JR:                    state_d = S_JUMP;
            CL_NOP:                           state_d = S_FETCH;
            default:                          state_d = S_ERROR;
          endcase
        end
      end
      S_EXEC:     state_d = S_ALU_WB;
      S_ALU_WB:   state_d = S_FETCH;
      S_MEM_ADDR: state_d = (class_q == CL_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready)    state_d = S_MEM_WB;
        else if (timeout) state_d = S_ERROR;
        else              wait_d  = wait_q + CW'(1);
      end
      S_MEM_WB: state_d = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready)    state_d = S_FETCH;
        else if (timeout) state_d = S_ERROR;
        else              wait_d  = wait_q + CW'(1);
      end
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_ERROR;
    endcase
    // FETCH->FETCH is a stall and ERROR only leaves through reset.
    retire_d = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_ERROR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      class_q  <= CL_NONE;
      wait_q   <= '0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      class_q  <= class_d;
      wait_q   <= wait_d;
      retire_q <= retire_d;
    end
  end

  // Everything is gated by reset so an in-flight strobe drops the moment reset asserts.
  always_comb begin
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    reg_we    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    alu_src_b = 1'b0;
    ext_sign  = 1'b0;
    reg_dst   = RD_RD;
    wd_sel    = WD_ALU;
    npc_sel   = NPC_PC4;
    alu_op    = ALU_NONE;
    err       = 1'b0;
    retire    = 1'b0;
    if (reset) begin
      retire = retire_q;
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
          pc_we   = mem_ready;
        end
        S_EXEC: begin
          case (class_q)
            CL_ADDU: alu_op = ALU_ADD;
            CL_SUBU: alu_op = ALU_SUB;
            CL_ORI:  begin alu_op = ALU_OR;  alu_src_b = 1'b1; end
            CL_LUI:  begin alu_op = ALU_LUI; alu_src_b = 1'b1; end
            default: alu_op = ALU_NONE;
          endcase
        end
        S_ALU_WB: begin
          reg_we  = 1'b1;
          wd_sel  = WD_ALU;
          reg_dst = is_i_type(class_q) ? RD_RT : RD_RD;
        end
        S_MEM_ADDR: begin
          alu_op    = ALU_ADD;
          alu_src_b = 1'b1;
          ext_sign  = 1'b1;
        end
        S_MEM_RD: mem_req = 1'b1;
        S_MEM_WB: begin
          reg_we  = 1'b1;
          reg_dst = RD_RT;
          wd_sel  = WD_MEM;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
        end
        S_BRANCH: begin
          alu_op  = ALU_SUB;
          npc_sel = NPC_BRANCH;
          pc_we   = zero;
        end
        S_JUMP: begin
          pc_we = 1'b1;
          if (class_q == CL_JAL) begin
            npc_sel = NPC_J26;
            reg_we  = 1'b1;
            reg_dst = RD_R31;
            wd_sel  = WD_PC;
          end else begin
            npc_sel = NPC_REG;
          end
        end
        S_ERROR: err = 1'b1;
        default: err = 1'b0;
      endcase
    end
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_mc_ctrl : directed self-checking bench for mc_ctrl
// Revision: 1.0
// ============================================================================
module tb_mc_ctrl;
  import mc_pkg::*;

  localparam int MW = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_we, ir_we, reg_we, mem_req, mem_we, alu_src_b, ext_sign;
  logic [1:0] reg_dst, wd_sel, npc_sel;
  logic [2:0] alu_op;
  logic       retire, err;
  logic [3:0] state;
  logic [17:0] obs;

  int checks = 0;
  int errors = 0;
  bit exp_ret;

  mc_ctrl #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we),
    .mem_req(mem_req), .mem_we(mem_we), .alu_src_b(alu_src_b), .ext_sign(ext_sign),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .npc_sel(npc_sel), .alu_op(alu_op),
    .retire(retire), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {pc_we, ir_we, reg_we, mem_req, mem_we, alu_src_b, ext_sign,
                reg_dst, wd_sel, npc_sel, alu_op, retire, err};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected output bundle in the same bit order as obs.
  function automatic logic [17:0] ov(input bit pw, input bit iw, input bit rw, input bit mq,
                                     input bit mw, input bit sb, input bit es,
                                     input logic [1:0] rd, input logic [1:0] ws,
                                     input logic [1:0] ns, input logic [2:0] ao,
                                     input bit rt, input bit er);
    return {pw, iw, rw, mq, mw, sb, es, rd, ws, ns, ao, rt, er};
  endfunction

  function automatic logic [17:0] fetch_o(input bit rdy, input bit ret);
    return ov(rdy, rdy, 0, 1, 0, 0, 0, RD_RD, WD_ALU, NPC_PC4, ALU_NONE, ret, 0);
  endfunction

  // Check the current cycle, then advance to 2ns past the next rising edge.
  task automatic cyc(input string tag, input logic [3:0] es, input logic [17:0] eo);
    #1;
    check_eq({tag, ".state"}, {28'd0, state}, {28'd0, es});
    check_eq({tag, ".outs"}, {14'd0, obs}, {14'd0, eo});
    @(posedge clk); #2;
  endtask

  task automatic do_fetch(input string tag);
    mem_ready = 1'b1;
    cyc({tag, ".fetch"}, S_FETCH, fetch_o(1'b1, exp_ret));
    exp_ret = 1'b1;
  endtask

  task automatic run_alu(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic [2:0] aop, input bit sb, input logic [1:0] rdst);
    opcode = op; funct = fn;
    do_fetch(tag);
    cyc({tag, ".dec"}, S_DECODE, '0);
    cyc({tag, ".exec"}, S_EXEC, ov(0, 0, 0, 0, 0, sb, 0, RD_RD, WD_ALU, NPC_PC4, aop, 0, 0));
    cyc({tag, ".wb"}, S_ALU_WB, ov(0, 0, 1, 0, 0, 0, 0, rdst, WD_ALU, NPC_PC4, ALU_NONE, 0, 0));
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    check_eq("rst.state", {28'd0, state}, {28'd0, S_FETCH});
    check_eq("rst.outs", {14'd0, obs}, 32'd0);
    reset = 1'b1;
    exp_ret = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = '0; funct = '0;
    exp_ret = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    check_eq("por.state", {28'd0, state}, {28'd0, S_FETCH});
    check_eq("por.outs", {14'd0, obs}, 32'd0);
    reset = 1'b1;

    run_alu("addu", OP_RTYPE, FN_ADDU, ALU_ADD, 1'b0, RD_RD);
    run_alu("subu", OP_RTYPE, FN_SUBU, ALU_SUB, 1'b0, RD_RD);
    run_alu("ori",  OP_ORI,   6'h15,   ALU_OR,  1'b1, RD_RT);
    run_alu("lui",  OP_LUI,   6'h00,   ALU_LUI, 1'b1, RD_RT);

    // lw with three wait cycles in MEM_RD
    opcode = OP_LW; funct = 6'h00;
    do_fetch("lw");
    cyc("lw.dec", S_DECODE, '0);
    cyc("lw.addr", S_MEM_ADDR, ov(0, 0, 0, 0, 0, 1, 1, RD_RD, WD_ALU, NPC_PC4, ALU_ADD, 0, 0));
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc("lw.rdwait", S_MEM_RD, ov(0, 0, 0, 1, 0, 0, 0, RD_RD, WD_ALU, NPC_PC4, ALU_NONE, 0, 0));
    mem_ready = 1'b1;
    cyc("lw.rd", S_MEM_RD, ov(0, 0, 0, 1, 0, 0, 0, RD_RD, WD_ALU, NPC_PC4, ALU_NONE, 0, 0));
    cyc("lw.wb", S_MEM_WB, ov(0, 0, 1, 0, 0, 0, 0, RD_RT, WD_MEM, NPC_PC4, ALU_NONE, 0, 0));

    // beq taken then not taken
    opcode = OP_BEQ; zero = 1'b1;
    do_fetch("beq1");
    cyc("beq1.dec", S_DECODE, '0);
    cyc("beq1.br", S_BRANCH, ov(1, 0, 0, 0, 0, 0, 0, RD_RD, WD_ALU, NPC_BRANCH, ALU_SUB, 0, 0));
    zero = 1'b0;
    do_fetch("beq0");
    cyc("beq0.dec", S_DECODE, '0);
    cyc("beq0.br", S_BRANCH, ov(0, 0, 0, 0, 0, 0, 0, RD_RD, WD_ALU, NPC_BRANCH, ALU_SUB, 0, 0));

    opcode = OP_JAL;
    do_fetch("jal");
    cyc("jal.dec", S_DECODE, '0);
    cyc("jal.jmp", S_JUMP, ov(1, 0, 1, 0, 0, 0, 0, RD_R31, WD_PC, NPC_J26, ALU_NONE, 0, 0));

    opcode = OP_RTYPE; funct = FN_JR;
    do_fetch("jr");
    cyc("jr.dec", S_DECODE, '0);
    cyc("jr.jmp", S_JUMP, ov(1, 0, 0, 0, 0, 0, 0, RD_RD, WD_ALU, NPC_REG, ALU_NONE, 0, 0));

    opcode = OP_SW; funct = 6'h00;
    do_fetch("sw");
    cyc("sw.dec", S_DECODE, '0);
    cyc("sw.addr", S_MEM_ADDR, ov(0, 0, 0, 0, 0, 1, 1, RD_RD, WD_ALU, NPC_PC4, ALU_ADD, 0, 0));
    cyc("sw.wr", S_MEM_WR, ov(0, 0, 0, 1, 1, 0, 0, RD_RD, WD_ALU, NPC_PC4, ALU_NONE, 0, 0));

    opcode = OP_RTYPE; funct = FN_NOP;
    do_fetch("nop");
    cyc("nop.dec", S_DECODE, '0);

    // reset asserted in the middle of a stalled store
    opcode = OP_SW;
    do_fetch("swr");
    cyc("swr.dec", S_DECODE, '0);
    cyc("swr.addr", S_MEM_ADDR, ov(0, 0, 0, 0, 0, 1, 1, RD_RD, WD_ALU, NPC_PC4, ALU_ADD, 0, 0));
    mem_ready = 1'b0;
    #1;
    check_eq("swr.wr.state", {28'd0, state}, {28'd0, S_MEM_WR});
    check_eq("swr.wr.mem_we", {31'd0, mem_we}, 32'd1);
    reset = 1'b0;
    #1;
    check_eq("swr.rst.state", {28'd0, state}, {28'd0, S_FETCH});
    check_eq("swr.rst.outs", {14'd0, obs}, 32'd0);
    @(posedge clk); #2;
    check_eq("swr.hold.outs", {14'd0, obs}, 32'd0);
    reset = 1'b1;
    exp_ret = 1'b0;
    run_alu("post", OP_ORI, 6'h00, ALU_OR, 1'b1, RD_RT);

    // illegal opcode
    opcode = 6'h3F;
    do_fetch("ill");
    cyc("ill.dec", S_DECODE, '0);
    cyc("ill.err0", S_ERROR, 18'd1);
    cyc("ill.err1", S_ERROR, 18'd1);

    // FETCH starved of mem_ready for MAX_WAIT+1 cycles
    pulse_reset();
    mem_ready = 1'b0;
    for (int i = 0; i <= MW; i++)
      cyc("tmo.fetch", S_FETCH, fetch_o(1'b0, 1'b0));
    cyc("tmo.err", S_ERROR, 18'd1);
    mem_ready = 1'b1;
    cyc("tmo.sticky", S_ERROR, 18'd1);

    // mem_ready arriving on the final allowed cycle wins over the timeout
    pulse_reset();
    opcode = OP_RTYPE; funct = FN_NOP;
    mem_ready = 1'b0;
    for (int i = 0; i < MW; i++)
      cyc("edge.fetch", S_FETCH, fetch_o(1'b0, 1'b0));
    mem_ready = 1'b1;
    cyc("edge.last", S_FETCH, fetch_o(1'b1, 1'b0));
    cyc("edge.dec", S_DECODE, '0);
    cyc("edge.ret", S_FETCH, fetch_o(1'b1, 1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: max consecutive cycles spent waiting on mem_ready in one memory state.
REQ-002 SHALL have port clk, input, 1: single clock, all state on the rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have ports opcode / funct, input, 6 each: instruction fields from the IR output.
REQ-005 SHALL have port zero, input, 1: ALU equality flag.
REQ-006 SHALL have port mem_ready, input, 1: memory handshake completion.
REQ-007 SHALL have output ports pc_we, ir_we, reg_we, mem_req, mem_we, alu_src_b, ext_sign, each 1 bit.
REQ-008 SHALL have output ports reg_dst (2: rd/rt/r31), wd_sel (2: ALU/MEM/PC), npc_sel (2: PC+4/BRANCH/J26/REG) and alu_op (3).
REQ-009 SHALL have output ports retire (1: one-cycle pulse per completed instruction), err (1: sticky fault) and state (4: debug view of the state register).

Function
REQ-010 SHALL implement FSM states FETCH, DECODE, EXEC, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP and ERROR.
REQ-011 FETCH SHALL drive mem_req=1 and mem_we=0.
- ir_we = pc_we = mem_ready (Mealy); npc_sel = PC+4.
- On mem_ready: go to DECODE; otherwise hold.
REQ-012 DECODE SHALL last exactly 1 cycle, latch the instruction class, and assert no write enables.
REQ-013 DECODE SHALL select the next state from the class.
- addu/subu/ori/lui -> EXEC.
- lw/sw -> MEM_ADDR.
- beq -> BRANCH.
- jal/jr -> JUMP.
- nop (all-zero word fields) -> FETCH.
- Any other opcode/funct -> ERROR.
REQ-014 EXEC SHALL drive alu_op ADD/SUB/OR/LUI and alu_src_b=1 for I-type; ext_sign=0 for ori; then go to ALU_WB.
REQ-015 ALU_WB SHALL assert reg_we=1 and wd_sel=ALU, with reg_dst=rd for R-type and rt for I-type, then go to FETCH.
REQ-016 MEM_ADDR SHALL drive alu_op=ADD, alu_src_b=1 and ext_sign=1, then go to MEM_RD (lw) or MEM_WR (sw).
REQ-017 MEM_RD SHALL drive mem_req=1 and go to MEM_WB on mem_ready.
REQ-018 MEM_WB SHALL assert reg_we=1, reg_dst=rt and wd_sel=MEM, then go to FETCH.
REQ-019 MEM_WR SHALL drive mem_req=1 and mem_we=1, and go to FETCH on mem_ready.
REQ-020 BRANCH SHALL drive alu_op=SUB, npc_sel=BRANCH and pc_we=zero, then go to FETCH.
REQ-021 JUMP SHALL assert pc_we=1, then go to FETCH.
- jal: npc_sel=J26, reg_we=1, reg_dst=r31, wd_sel=PC.
- jr: npc_sel=REG.
REQ-022 Every output not named for a state SHALL be 0 in that state.
REQ-023 retire SHALL be 1 for exactly one cycle on every transition into FETCH from any state other than FETCH or ERROR.
REQ-024 A wait counter SHALL clear on entry to FETCH/MEM_RD/MEM_WR and increment each cycle mem_ready=0 in those states.
REQ-025 When the counter equals MAX_WAIT with mem_ready still 0, the FSM SHALL enter ERROR; mem_ready=1 on that same cycle SHALL win.
REQ-026 ERROR SHALL deassert all strobes and hold err=1 until reset.
REQ-027 Latency SHALL be fixed at zero memory wait.
- ALU ops: 4 cycles.
- lw: 5 cycles.
- sw: 4 cycles.
- beq/jal/jr: 3 cycles.
- nop: 2 cycles.

Reset
REQ-028 While reset=0, state SHALL be FETCH, the counter and latched class SHALL be 0, err=0, and all strobe outputs SHALL be forced to 0 combinationally, including mid-transaction.
REQ-029 After reset deasserts, the first rising edge SHALL begin a FETCH handshake.

Structure
REQ-030 State encodings, class codes, alu_op codes, npc_sel/wd_sel/reg_dst codes and opcode/funct constants SHALL reside in the shared package mc_pkg.
REQ-031 The instruction classifier SHALL be the sub-module mc_decode (combinational: opcode, funct -> class, illegal); the FSM, counter and output decode SHALL stay in mc_ctrl.

Verification
REQ-032 addu with mem_ready tied 1 -> states FETCH, DECODE, EXEC, ALU_WB; reg_we=1 and reg_dst=rd in cycle 4; retire at the next FETCH.
REQ-033 lw with mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then MEM_WB with wd_sel=MEM; no err.
REQ-034 beq with zero=1, then beq with zero=0 -> pc_we=1 with npc_sel=BRANCH in the first; pc_we=0 in the second; both 3 cycles.
REQ-035 mem_ready held 0 in FETCH -> ERROR after MAX_WAIT+1 cycles, err=1 sticky, all enables 0.
REQ-036 reset pulled low during MEM_WR with mem_we=1 -> mem_we=0 immediately, state=FETCH; on release a normal fetch.
REQ-037 opcode=6'h3F -> DECODE then ERROR; jal -> reg_dst=r31, wd_sel=PC, npc_sel=J26.
